// File: rtl/riscv_dmem_if.sv
// Data-memory bus interface: one outstanding load/store, IDLE -> ADDR -> DATA handshake.
// Optional macro RISCV_DMEM_MISALIGN_CHECK_EN completes misaligned accesses locally without a bus cycle.
package riscv_dmem_pkg;
  typedef enum logic [2:0] {
    UNDEF_SIZE = 3'd0,
    BYTE       = 3'd1,
    HWORD      = 3'd2,
    WORD       = 3'd3,
    DWORD      = 3'd4
  } biu_size_t;
endpackage

module riscv_dmem_if
  import riscv_dmem_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            dmem_req,
  input  logic [XLEN-1:0] dmem_adr,
  input  logic [XLEN-1:0] dmem_d,
  input  logic            dmem_we,
  input  biu_size_t       dmem_size,
  output logic            dmem_ack,
  output logic [XLEN-1:0] dmem_q,
  output logic            dmem_misaligned,
  output logic            dmem_page_fault,
  output logic            bus_req,
  output logic [XLEN-1:0] bus_adr,
  output logic            bus_we,
  output logic [3:0]      bus_be,
  output logic [XLEN-1:0] bus_d,
  input  logic            bus_gnt,
  input  logic            bus_rvalid,
  input  logic [XLEN-1:0] bus_q,
  input  logic            bus_err
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] adr_q, d_q, q_q;
  logic [3:0]      be_q;
  logic            we_q, ack_q, mis_q, pf_q;
  logic            accept, misaligned, done;

  function automatic logic [3:0] calc_be(input biu_size_t size, input logic [1:0] a);
    case (size)
      BYTE:    calc_be = 4'b0001 << a;
      HWORD:   calc_be = 4'b0011 << a;
      WORD:    calc_be = 4'b1111;
      default: calc_be = 4'b0000;
    endcase
  endfunction

`ifdef RISCV_DMEM_MISALIGN_CHECK_EN
  function automatic logic is_misaligned(input biu_size_t size, input logic [1:0] a);
    case (size)
      BYTE:    is_misaligned = 1'b0;
      HWORD:   is_misaligned = a[0];
      WORD:    is_misaligned = (a != 2'b00);
      default: is_misaligned = 1'b1;
    endcase
  endfunction

  assign misaligned = is_misaligned(dmem_size, dmem_adr[1:0]);
`else
  assign misaligned = 1'b0;
`endif

  // A request seen during the ack cycle is the tail of the previous access, not a new one.
  assign accept = (state_q == IDLE) && dmem_req && !ack_q;
  assign done   = (state_q == DATA) && bus_rvalid;

  always_comb begin
    state_d = state_q;
    bus_req = 1'b0;
    case (state_q)
      IDLE: if (accept && !misaligned) state_d = ADDR;
      ADDR: begin
        bus_req = 1'b1;
        if (bus_gnt) state_d = DATA;
      end
      DATA: if (bus_rvalid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      adr_q   <= '0;
      d_q     <= '0;
      be_q    <= '0;
      we_q    <= 1'b0;
      ack_q   <= 1'b0;
      q_q     <= '0;
      mis_q   <= 1'b0;
      pf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ack_q   <= 1'b0;
      if (accept) begin
        adr_q <= {dmem_adr[XLEN-1:2], 2'b00};
        we_q  <= dmem_we;
        be_q  <= calc_be(dmem_size, dmem_adr[1:0]);
        d_q   <= dmem_we ? dmem_d : '0;
        if (misaligned) begin
          ack_q <= 1'b1;
          mis_q <= 1'b1;
          pf_q  <= 1'b0;
        end
      end
      if (done) begin
        ack_q <= 1'b1;
        q_q   <= bus_q;
        pf_q  <= bus_err;
        mis_q <= 1'b0;
      end
    end
  end

  assign dmem_ack        = ack_q;
  assign dmem_q          = q_q;
  assign dmem_misaligned = mis_q;
  assign dmem_page_fault = pf_q;
  assign bus_adr         = adr_q;
  assign bus_we          = we_q;
  assign bus_be          = be_q;
  assign bus_d           = d_q;

endmodule

// File: tb/tb_riscv_dmem_if.sv
// Directed bench for riscv_dmem_if; expectations follow RISCV_DMEM_MISALIGN_CHECK_EN when defined.
module tb_riscv_dmem_if;
  import riscv_dmem_pkg::*;

  logic        clk = 1'b0;
  logic        rstn;
  logic        dmem_req;
  logic [31:0] dmem_adr, dmem_d;
  logic        dmem_we;
  biu_size_t   dmem_size;
  logic        dmem_ack;
  logic [31:0] dmem_q;
  logic        dmem_misaligned, dmem_page_fault;
  logic        bus_req;
  logic [31:0] bus_adr;
  logic        bus_we;
  logic [3:0]  bus_be;
  logic [31:0] bus_d;
  logic        bus_gnt, bus_rvalid, bus_err;
  logic [31:0] bus_q;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  riscv_dmem_if #(.XLEN(32)) dut (
    .clk(clk), .rstn(rstn),
    .dmem_req(dmem_req), .dmem_adr(dmem_adr), .dmem_d(dmem_d),
    .dmem_we(dmem_we), .dmem_size(dmem_size),
    .dmem_ack(dmem_ack), .dmem_q(dmem_q),
    .dmem_misaligned(dmem_misaligned), .dmem_page_fault(dmem_page_fault),
    .bus_req(bus_req), .bus_adr(bus_adr), .bus_we(bus_we), .bus_be(bus_be), .bus_d(bus_d),
    .bus_gnt(bus_gnt), .bus_rvalid(bus_rvalid), .bus_q(bus_q), .bus_err(bus_err)
  );

  // Runs one access with a responding bus model. Must be entered just after a rising edge
  // with the DUT idle. lat = edges from the accept edge to the first cycle ack is seen (-1 on timeout).
  task automatic do_access(input logic [31:0] adr, input logic [31:0] d, input logic we,
                           input biu_size_t size, input int gd, input int rd,
                           input logic [31:0] q, input logic err,
                           output int lat, output int reqc, output logic [31:0] adr_s,
                           output logic [31:0] d_s, output logic [3:0] be_s, output logic we_s);
    int datac;
    dmem_req = 1'b1; dmem_adr = adr; dmem_d = d; dmem_we = we; dmem_size = size;
    lat = -1; reqc = 0; datac = 0;
    adr_s = '0; d_s = '0; be_s = '0; we_s = 1'b0;
    for (int k = 0; k < 40 && lat < 0; k++) begin
      @(posedge clk); #1;
      dmem_req = 1'b0; bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_err = 1'b0;
      if (dmem_ack) lat = k + 1;
      else if (bus_req) begin
        reqc++;
        adr_s = bus_adr; be_s = bus_be; we_s = bus_we; d_s = bus_d;
        if (reqc == gd + 1) bus_gnt = 1'b1;
      end else if (reqc > 0) begin
        datac++;
        if (datac == rd + 1) begin
          bus_rvalid = 1'b1; bus_q = q; bus_err = err;
        end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    int lat, reqc; logic [31:0] a, dd; logic [3:0] be; logic w;
    rstn = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({bus_req, dmem_ack, dmem_misaligned, dmem_page_fault, bus_we} !== 5'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b expected 00000",
                         {bus_req, dmem_ack, dmem_misaligned, dmem_page_fault, bus_we});
    end
    checks++;
    if ({dmem_q, bus_adr, bus_d, bus_be} !== 100'b0) begin
      errors++; $display("FAIL reset_data: q=%h adr=%h d=%h be=%h expected all 0",
                         dmem_q, bus_adr, bus_d, bus_be);
    end
    rstn = 1'b1;
    do_access(32'h40, 32'h0, 1'b0, WORD, 0, 0, 32'h1234_5678, 1'b0, lat, reqc, a, dd, be, w);
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL first_edge_accept: lat=%0d expected 3", lat); end
    checks++;
    if (dmem_q !== 32'h1234_5678) begin
      errors++; $display("FAIL first_edge_q: got %h expected 12345678", dmem_q);
    end
  endtask

  task automatic test_word_load();
    int lat, reqc; logic [31:0] a, dd; logic [3:0] be; logic w;
    do_access(32'h100, 32'hFFFF_FFFF, 1'b0, WORD, 0, 0, 32'hDEAD_BEEF, 1'b0, lat, reqc, a, dd, be, w);
    checks++;
    if (lat !== 3) begin errors++; $display("FAIL word_lat: got %0d expected 3", lat); end
    checks++;
    if (be !== 4'hF || a !== 32'h100 || w !== 1'b0 || dd !== 32'h0) begin
      errors++; $display("FAIL word_bus: be=%h adr=%h we=%b d=%h expected f 00000100 0 00000000",
                         be, a, w, dd);
    end
    checks++;
    if (dmem_q !== 32'hDEAD_BEEF || dmem_ack !== 1'b0) begin
      errors++; $display("FAIL word_hold: q=%h ack=%b expected deadbeef 0", dmem_q, dmem_ack);
    end
  endtask

  task automatic test_byte_store();
    int lat, reqc; logic [31:0] a, dd; logic [3:0] be; logic w;
    do_access(32'h203, 32'hAA00_0000, 1'b1, BYTE, 4, 0, 32'h0, 1'b0, lat, reqc, a, dd, be, w);
    checks++;
    if (reqc !== 5) begin errors++; $display("FAIL sb_req_cycles: got %0d expected 5", reqc); end
    checks++;
    if (be !== 4'b1000 || a !== 32'h200 || w !== 1'b1 || dd !== 32'hAA00_0000) begin
      errors++; $display("FAIL sb_bus: be=%b adr=%h we=%b d=%h expected 1000 00000200 1 aa000000",
                         be, a, w, dd);
    end
    checks++;
    if (lat !== 7) begin errors++; $display("FAIL sb_lat: got %0d expected 7", lat); end
  endtask

  task automatic test_byte_enables();
    int lat, reqc; logic [31:0] a, dd; logic [3:0] be; logic w;
    logic [31:0] adr_t [5];
    biu_size_t   sz_t  [5];
    logic [3:0]  be_t  [5];
    logic        iss_t [5];
    adr_t = '{32'h201, 32'h102, 32'h100, 32'h108, 32'h10C};
    sz_t  = '{BYTE, HWORD, HWORD, DWORD, UNDEF_SIZE};
    be_t  = '{4'b0010, 4'b1100, 4'b0011, 4'b0000, 4'b0000};
`ifdef RISCV_DMEM_MISALIGN_CHECK_EN
    iss_t = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
`else
    iss_t = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
`endif
    for (int i = 0; i < 5; i++) begin
      do_access(adr_t[i], 32'h0, 1'b0, sz_t[i], 0, 0, 32'h0BAD_0000 + i, 1'b0, lat, reqc, a, dd, be, w);
      checks++;
      if (reqc !== (iss_t[i] ? 1 : 0)) begin
        errors++; $display("FAIL be_issue[%0d]: req cycles=%0d expected %0d", i, reqc, iss_t[i] ? 1 : 0);
      end
      if (iss_t[i]) begin
        checks++;
        if (be !== be_t[i] || a !== {adr_t[i][31:2], 2'b00}) begin
          errors++; $display("FAIL be_vec[%0d]: be=%b adr=%h expected %b %h",
                             i, be, a, be_t[i], {adr_t[i][31:2], 2'b00});
        end
      end
    end
  endtask

  task automatic test_misaligned();
    int lat, reqc; logic [31:0] a, dd; logic [3:0] be; logic w;
    do_access(32'h180, 32'h0, 1'b0, WORD, 0, 0, 32'h5555_5555, 1'b0, lat, reqc, a, dd, be, w);
    do_access(32'h102, 32'h0, 1'b0, WORD, 0, 0, 32'h6666_6666, 1'b0, lat, reqc, a, dd, be, w);
`ifdef RISCV_DMEM_MISALIGN_CHECK_EN
    checks++;
    if (lat !== 1 || reqc !== 0) begin
      errors++; $display("FAIL mis_local: lat=%0d req cycles=%0d expected 1 0", lat, reqc);
    end
    checks++;
    if (dmem_misaligned !== 1'b1 || dmem_q !== 32'h5555_5555) begin
      errors++; $display("FAIL mis_status: mis=%b q=%h expected 1 55555555", dmem_misaligned, dmem_q);
    end
`else
    checks++;
    if (lat !== 3 || reqc !== 1 || be !== 4'hF || a !== 32'h100) begin
      errors++; $display("FAIL mis_bus: lat=%0d reqc=%0d be=%h adr=%h expected 3 1 f 00000100",
                         lat, reqc, be, a);
    end
    checks++;
    if (dmem_misaligned !== 1'b0 || dmem_q !== 32'h6666_6666) begin
      errors++; $display("FAIL mis_status: mis=%b q=%h expected 0 66666666", dmem_misaligned, dmem_q);
    end
`endif
  endtask

  task automatic test_bus_error();
    int lat, reqc; logic [31:0] a, dd; logic [3:0] be; logic w;
    do_access(32'h300, 32'h0, 1'b0, WORD, 1, 2, 32'h7777_7777, 1'b1, lat, reqc, a, dd, be, w);
    checks++;
    if (dmem_page_fault !== 1'b1 || lat !== 6) begin
      errors++; $display("FAIL err_set: pf=%b lat=%0d expected 1 6", dmem_page_fault, lat);
    end
    do_access(32'h304, 32'h0, 1'b0, WORD, 0, 0, 32'h8888_8888, 1'b0, lat, reqc, a, dd, be, w);
    checks++;
    if (dmem_page_fault !== 1'b0 || dmem_q !== 32'h8888_8888) begin
      errors++; $display("FAIL err_clear: pf=%b q=%h expected 0 88888888", dmem_page_fault, dmem_q);
    end
  endtask

  task automatic test_reset_in_data();
    int lat, reqc; logic [31:0] a, dd; logic [3:0] be; logic w;
    dmem_req = 1'b1; dmem_adr = 32'h500; dmem_we = 1'b0; dmem_size = WORD;
    @(posedge clk); #1;
    dmem_req = 1'b0; bus_gnt = 1'b1;
    @(posedge clk); #1;
    bus_gnt = 1'b0;
    #2 rstn = 1'b0;
    #1;
    checks++;
    if ({bus_req, dmem_ack, dmem_q, bus_adr, bus_be, bus_we} !== 71'b0) begin
      errors++; $display("FAIL rst_data_zero: req=%b ack=%b q=%h adr=%h be=%h we=%b expected all 0",
                         bus_req, dmem_ack, dmem_q, bus_adr, bus_be, bus_we);
    end
    @(posedge clk); #1;
    rstn = 1'b1; bus_rvalid = 1'b1; bus_q = 32'h9999_9999;
    @(posedge clk); #1;
    bus_rvalid = 1'b0;
    checks++;
    if (dmem_ack !== 1'b0 || dmem_q !== 32'h0) begin
      errors++; $display("FAIL stray_rvalid: ack=%b q=%h expected 0 00000000", dmem_ack, dmem_q);
    end
    do_access(32'h504, 32'h0, 1'b0, WORD, 0, 0, 32'hABCD_0123, 1'b0, lat, reqc, a, dd, be, w);
    checks++;
    if (lat !== 3 || dmem_q !== 32'hABCD_0123) begin
      errors++; $display("FAIL rst_recover: lat=%0d q=%h expected 3 abcd0123", lat, dmem_q);
    end
  endtask

  task automatic test_back_to_back();
    dmem_req = 1'b1; dmem_adr = 32'h600; dmem_we = 1'b0; dmem_size = WORD;
    @(posedge clk); #1;
    bus_gnt = 1'b1;
    @(posedge clk); #1;
    bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_q = 32'h1111_1111;
    @(posedge clk); #1;
    bus_rvalid = 1'b0;
    checks++;
    if (dmem_ack !== 1'b1 || dmem_q !== 32'h1111_1111) begin
      errors++; $display("FAIL b2b_first: ack=%b q=%h expected 1 11111111", dmem_ack, dmem_q);
    end
    dmem_adr = 32'h604;
    @(posedge clk); #1;
    checks++;
    if (bus_req !== 1'b0 || dmem_ack !== 1'b0) begin
      errors++; $display("FAIL b2b_no_accept_on_ack: req=%b ack=%b expected 0 0", bus_req, dmem_ack);
    end
    @(posedge clk); #1;
    checks++;
    if (bus_req !== 1'b1 || bus_adr !== 32'h604) begin
      errors++; $display("FAIL b2b_second_accept: req=%b adr=%h expected 1 00000604", bus_req, bus_adr);
    end
    dmem_req = 1'b0; bus_rvalid = 1'b1; bus_q = 32'h0BAD_0BAD;
    @(posedge clk); #1;
    bus_rvalid = 1'b0; bus_gnt = 1'b1;
    checks++;
    if (dmem_ack !== 1'b0 || bus_req !== 1'b1 || dmem_q !== 32'h1111_1111) begin
      errors++; $display("FAIL b2b_early_rvalid: ack=%b req=%b q=%h expected 0 1 11111111",
                         dmem_ack, bus_req, dmem_q);
    end
    @(posedge clk); #1;
    bus_gnt = 1'b0; bus_rvalid = 1'b1; bus_q = 32'h2222_2222;
    @(posedge clk); #1;
    bus_rvalid = 1'b0;
    checks++;
    if (dmem_ack !== 1'b1 || dmem_q !== 32'h2222_2222) begin
      errors++; $display("FAIL b2b_second_done: ack=%b q=%h expected 1 22222222", dmem_ack, dmem_q);
    end
    @(posedge clk); #1;
    checks++;
    if (dmem_ack !== 1'b0 || dmem_q !== 32'h2222_2222) begin
      errors++; $display("FAIL b2b_pulse: ack=%b q=%h expected 0 22222222", dmem_ack, dmem_q);
    end
  endtask

  initial begin
    rstn = 1'b0; dmem_req = 1'b0; dmem_adr = '0; dmem_d = '0; dmem_we = 1'b0;
    dmem_size = UNDEF_SIZE; bus_gnt = 1'b0; bus_rvalid = 1'b0; bus_q = '0; bus_err = 1'b0;
    test_reset();
    test_word_load();
    test_byte_store();
    test_byte_enables();
    test_misaligned();
    test_bus_error();
    test_reset_in_data();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/riscv_dmem_if.md
RISCV_DMEM_IF -- requirements
Module: riscv_dmem_if

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning data/address width; only 32 is supported.
REQ-002 SHALL have port clk  input  1  sole clock, rising edge.
REQ-003 SHALL have port rstn  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port dmem_req  input  1  access request from the load/store unit.
REQ-005 SHALL have ports dmem_adr and dmem_d  input  XLEN each  address and pre-shifted store data.
REQ-006 SHALL have ports dmem_we  input  1  store flag; dmem_size  input  biu_size_t  access size.
REQ-007 SHALL have port dmem_ack  output  1  one-cycle completion pulse.
REQ-008 SHALL have port dmem_q  output  XLEN  raw (unextended) load word.
REQ-009 SHALL have ports dmem_misaligned and dmem_page_fault  output  1 each  completion status, valid with dmem_ack.
REQ-010 SHALL have ports bus_req  output  1, bus_adr  output  XLEN, bus_we  output  1, bus_be  output  4 and bus_d  output  XLEN, forming the bus request.
REQ-011 SHALL have ports bus_gnt  input  1, bus_rvalid  input  1, bus_q  input  XLEN and bus_err  input  1, forming the bus response.

Function
REQ-012 SHALL implement FSM states IDLE, ADDR and DATA, with one outstanding access maximum.
REQ-013 SHALL, in IDLE with dmem_req=1, capture adr, we, size and d and move to ADDR on the next edge (accept).
REQ-014 SHALL, in ADDR, drive bus_req=1 with the captured fields held stable until bus_gnt=1, then go to DATA.
REQ-015 SHALL, in DATA, wait for bus_rvalid=1 (reads and writes), then pulse dmem_ack for 1 cycle, register bus_q into dmem_q and bus_err into dmem_page_fault, and return to IDLE.
REQ-016 SHALL give a minimum latency of 3 cycles from accept to dmem_ack (gnt and rvalid each asserted on the first possible cycle).
REQ-017 SHALL ignore bus_rvalid while in IDLE or ADDR.
REQ-018 SHALL ignore bus_gnt outside ADDR.
REQ-019 SHALL compute bus_be as: BYTE -> 4'b0001<<adr[1:0]; HWORD -> 4'b0011<<adr[1:0]; WORD -> 4'b1111; DWORD/UNDEF_SIZE -> 4'b0000.
REQ-020 SHALL drive bus_adr as the captured address with bits [1:0] forced to 0.
REQ-021 SHALL not accept dmem_req on the cycle dmem_ack is high; the requester deasserts dmem_req after ack, and a request still high the cycle after ack is a new access.
REQ-022 SHALL hold dmem_q, dmem_misaligned and dmem_page_fault from their last ack until the next ack.
REQ-023 SHALL drive bus_d with the captured store data for writes and 0 for reads.
REQ-024 SHALL hold bus_req=0 in IDLE and DATA.

Reset
REQ-025 SHALL, on rstn low at any time including mid-access, force the FSM to IDLE and set bus_req, dmem_ack, dmem_misaligned and dmem_page_fault to 0 and dmem_q, bus_adr, bus_d, bus_be and bus_we to 0, discarding any in-flight access.
REQ-026 SHALL, on the first edge after reset release, accept a dmem_req asserted on that edge.

Configuration
REQ-027 SHALL provide macro RISCV_DMEM_MISALIGN_CHECK_EN; when defined, an access with HWORD and adr[0]=1, WORD and adr[1:0]!=0, or DWORD/UNDEF_SIZE is not issued to the bus, and the block goes IDLE->DATA-less completion, pulsing dmem_ack with dmem_misaligned=1 exactly 1 cycle after accept while leaving dmem_q unchanged.
REQ-028 SHALL, when RISCV_DMEM_MISALIGN_CHECK_EN is undefined, tie dmem_misaligned to 0 and issue every access to the bus using the REQ-019 byte enables.

Verification
REQ-029 SHALL verify a WORD load: adr=0x100, gnt and rvalid immediate, bus_q=0xDEADBEEF -> bus_be=4'hF and bus_adr=0x100, with dmem_ack and dmem_q=0xDEADBEEF 3 cycles after accept.
REQ-030 SHALL verify an SB store: adr=0x203, d=0xAA000000, gnt delayed 4 cycles -> bus_req held 5 cycles, bus_be=4'b1000, bus_adr=0x200, bus_we=1.
REQ-031 SHALL verify a misaligned WORD load (macro defined): adr=0x102 -> bus_req never asserted, dmem_ack and dmem_misaligned=1 1 cycle after accept; macro undefined -> normal bus access, dmem_misaligned=0.
REQ-032 SHALL verify an error response: bus_err=1 with rvalid -> dmem_ack with dmem_page_fault=1, cleared on the next good access.
REQ-033 SHALL verify reset in DATA: rstn pulsed low before rvalid -> outputs zero, a later stray rvalid produces no dmem_ack, and the next request completes normally.
REQ-034 SHALL verify back-to-back access: dmem_req held through ack -> second access accepted the cycle after ack, and no rvalid early in ADDR is consumed.
